sa_skew_feeder: RTL and testbench

- Transmit-side feeder for the approximate-PE systolic array. It drives the ifmap edge that the PE rows consume.
- Accepts one ROWS-wide ifmap vector per handshake and buffers it in a small FIFO.
- Emits each vector diagonally skewed: row r is delayed r cycles so operands meet their weights in step.
- Inserts ROWS-cycle drain gaps between tiles and flags when the last operand of a tile enters the bottom row.

---
 rtl/sa_pkg.sv | 23 ++
 rtl/sa_feed_fifo.sv | 69 ++++++
 rtl/sa_skew_feeder.sv | 178 +++++++++++++++++
 tb/tb_sa_skew_feeder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sa_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sa_pkg
// Description : Shared definitions for the systolic-array ifmap feeder:
//               default geometry, feeder FSM state encoding and the ifmap
//               element type alias.
// Revision    : 1.0 - initial release
// ============================================================================
package sa_pkg;

    localparam int DW_DEF   = 16;
    localparam int ROWS_DEF = 4;

    // Feeder FSM state encoding
    localparam int              c_st_w      = 2;
    localparam logic [c_st_w-1:0] c_st_idle   = 2'd0;
    localparam logic [c_st_w-1:0] c_st_stream = 2'd1;
    localparam logic [c_st_w-1:0] c_st_drain  = 2'd2;

    typedef logic [DW_DEF-1:0] ifmap_elem_t;

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_feed_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sa_feed_fifo
// Description : Single-clock synchronous FIFO holding {last, vector} words for
//               the skew feeder. Full/empty/count come from a registered count.
//               Caller guarantees no push when full and no pop when empty.
// Ports       : clk, reset      - clock, synchronous active-high reset
//               i_push, i_wdata - write strobe and word
//               i_pop, o_rdata  - read strobe and head-of-queue word
//               o_full, o_empty, o_count - occupancy status
// Revision    : 1.0 - initial release
// ============================================================================
module sa_feed_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;

    // Storage has no reset: only entries covered by the count are ever read.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are exactly log2(DEPTH) wide so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_full  = (r_count == (c_aw+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule : sa_feed_fifo
`default_nettype wire

// File: rtl/sa_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : sa_skew_feeder
// Description : Ifmap edge feeder for the systolic array. Buffers ROWS-wide
//               vectors in a FIFO, emits them diagonally skewed (row r delayed
//               r cycles), separates tiles with drain gaps and pulses tile_done
//               when a tile's last operand reaches the bottom row.
// Ports       : clk, reset         - clock, synchronous active-high reset
//               s_valid/s_ready    - upstream vector handshake
//               s_data, s_last     - vector (lane r = s_data[r*DW +: DW]), tile end
//               array_en           - array advance enable (low freezes feeder)
//               ifmap_o/ifmap_vld_o- skewed per-row data and valid
//               tile_done          - last operand of a tile at row ROWS-1
//               busy               - FSM active or FIFO non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module sa_skew_feeder
    import sa_pkg::*;
#(
    parameter int ROWS  = ROWS_DEF,
    parameter int DW    = DW_DEF,
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [ROWS*DW-1:0] s_data,
    input  logic               s_last,
    input  logic               array_en,
    output logic [ROWS*DW-1:0] ifmap_o,
    output logic [ROWS-1:0]    ifmap_vld_o,
    output logic               tile_done,
    output logic               busy
);

    localparam int c_fw = ROWS*DW + 1;
    localparam int c_cw = (ROWS > 2) ? $clog2(ROWS) : 1;

    logic [c_fw-1:0]          w_rdata;
    logic                     w_full;
    logic                     w_empty;
    logic [$clog2(DEPTH):0]   w_count;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_pop_last;

    logic [c_st_w-1:0]        r_state;
    logic [c_st_w-1:0]        w_state_nxt;
    logic [c_cw-1:0]          r_cnt;
    logic [c_cw-1:0]          w_cnt_nxt;

    logic                     w_in_vld;
    logic [ROWS*DW-1:0]       w_in_data;
    logic                     w_in_last;
    logic [ROWS-1:0]          r_last;

    // ------------------------------------------------------------------
    // Input buffer
    // ------------------------------------------------------------------
    assign s_ready = !w_full && !reset;
    assign w_push  = s_valid && s_ready;

    sa_feed_fifo #(
        .WIDTH (c_fw),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_wdata ({s_last, s_data}),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_pop      = array_en && !w_empty &&
                        ((r_state == c_st_idle) || (r_state == c_st_stream));
    assign w_pop_last = w_rdata[ROWS*DW];

    // ------------------------------------------------------------------
    // Feeder FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The drain lasts ROWS-1 enabled cycles: the counter leaves DRAIN on the
    // step that takes it to zero, so the next pop lands exactly ROWS cycles
    // after a tile's last pop and tiles never share a diagonal column.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            c_st_idle, c_st_stream: begin
                if (w_pop) begin
                    if (w_pop_last) begin
                        w_state_nxt = c_st_drain;
                        w_cnt_nxt   = c_cw'(ROWS-1);
                    end else begin
                        w_state_nxt = c_st_stream;
                    end
                end
            end
            c_st_drain: begin
                if (array_en) begin
                    if (r_cnt <= c_cw'(1)) begin
                        w_state_nxt = c_st_idle;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt   = r_cnt - 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Skew lines: row r has r+1 stages; a non-popping enabled cycle shifts
    // in a zero bubble so invalid stages always carry zero data.
    // ------------------------------------------------------------------
    assign w_in_vld  = w_pop;
    assign w_in_data = w_pop ? w_rdata[ROWS*DW-1:0] : '0;
    assign w_in_last = w_pop && w_pop_last;

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [DW-1:0] r_dat [0:r];
        logic [r:0]    r_vld;

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k <= r; k++) begin
                    r_dat[k] <= '0;
                end
                r_vld <= '0;
            end else if (array_en) begin
                r_dat[0] <= w_in_data[r*DW +: DW];
                r_vld[0] <= w_in_vld;
                for (int k = 1; k <= r; k++) begin
                    r_dat[k] <= r_dat[k-1];
                    r_vld[k] <= r_vld[k-1];
                end
            end
        end

        assign ifmap_o[r*DW +: DW] = r_dat[r];
        assign ifmap_vld_o[r]      = r_vld[r];
    end

    // The last flag rides alongside the bottom row only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last <= '0;
        end else if (array_en) begin
            r_last <= {r_last[ROWS-2:0], w_in_last};
        end
    end

    // Gating with array_en gives one pulse even if the last operand sits at
    // the bottom row across a freeze: it is masked while frozen and shifts
    // out on the first enabled edge.
    assign tile_done = r_last[ROWS-1] && ifmap_vld_o[ROWS-1] && array_en && !reset;
    assign busy      = (r_state != c_st_idle) || (w_count != '0);

endmodule : sa_skew_feeder
`default_nettype wire

// File: tb/tb_sa_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sa_skew_feeder
// Description : Directed self-checking bench for sa_skew_feeder (ROWS=4,
//               DW=16, DEPTH=8). Expected row outputs are derived from the
//               hand-planned pop schedule of each scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sa_skew_feeder;

    localparam int ROWS  = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_valid;
    logic               s_ready;
    logic [ROWS*DW-1:0] s_data;
    logic               s_last;
    logic               array_en;
    logic [ROWS*DW-1:0] ifmap_o;
    logic [ROWS-1:0]    ifmap_vld_o;
    logic               tile_done;
    logic               busy;

    always #5 clk = ~clk;

    sa_skew_feeder #(
        .ROWS  (ROWS),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .array_en    (array_en),
        .ifmap_o     (ifmap_o),
        .ifmap_vld_o (ifmap_vld_o),
        .tile_done   (tile_done),
        .busy        (busy)
    );

    int n_err = 0;
    int n_chk = 0;

    // Scenario tables: vectors, last flags and planned pop index (in enabled cycles)
    logic [63:0] pv [16];
    logic        pl [16];
    int          pt [16];
    int          npop;
    int          st_s;
    int          st_l;
    int          push_until;
    logic        rdy_seen  [16];
    logic        busy_seen [16];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mkvec(input logic [15:0] l0);
        logic [63:0] v;
        v = '0;
        for (int r = 0; r < ROWS; r++) begin
            v[r*DW +: DW] = l0 + 16'(r);
        end
        return v;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic preload(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            array_en = 1'b0;
            s_valid  = 1'b1;
            s_data   = pv[i];
            s_last   = pl[i];
            #1;
            check("preload_ready", 64'(s_ready), 64'd1);
        end
    endtask

    // Runs ncyc cycles with array_en low in [st_s, st_s+st_l); row r at a cycle
    // that has seen e enabled edges shows the vector popped at enabled index e-1-r.
    task automatic expect_run(input string tag, input int ncyc);
        int          e;
        int          j;
        logic        en;
        logic [63:0] exp_d;
        logic [3:0]  exp_v;
        logic        exp_td;
        e = 0;
        for (int k = 0; k < ncyc; k++) begin
            step();
            en       = !(k >= st_s && k < st_s + st_l);
            array_en = en;
            s_valid  = (k < push_until);
            #1;
            exp_d  = '0;
            exp_v  = '0;
            exp_td = 1'b0;
            for (int r = 0; r < ROWS; r++) begin
                j = e - 1 - r;
                for (int p = 0; p < npop; p++) begin
                    if (pt[p] == j) begin
                        exp_v[r]          = 1'b1;
                        exp_d[r*DW +: DW] = pv[p][r*DW +: DW];
                        if (r == ROWS-1 && pl[p] && en) exp_td = 1'b1;
                    end
                end
            end
            check({tag, "_data"}, ifmap_o, exp_d);
            check({tag, "_vld"}, 64'(ifmap_vld_o), 64'(exp_v));
            check({tag, "_tile_done"}, 64'(tile_done), 64'(exp_td));
            rdy_seen[k]  = s_ready;
            busy_seen[k] = busy;
            if (en) e++;
        end
    endtask

    task automatic setup_tile3();
        pv[0] = mkvec(16'h030E); pl[0] = 1'b0; pt[0] = 0;
        pv[1] = mkvec(16'hF185); pl[1] = 1'b0; pt[1] = 1;
        pv[2] = mkvec(16'hFF19); pl[2] = 1'b1; pt[2] = 2;
        npop = 3; st_s = 0; st_l = 0; push_until = 0;
    endtask

    initial begin
        reset    = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        s_last   = 1'b0;
        array_en = 1'b0;

        // 1: reset and idle
        step(); step();
        #1;
        check("rst_ready_low", 64'(s_ready), 64'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step();
            #1;
            check("idle_ready", 64'(s_ready), 64'd1);
            check("idle_busy", 64'(busy), 64'd0);
            check("idle_vld", 64'(ifmap_vld_o), 64'd0);
            check("idle_data", ifmap_o, 64'd0);
        end

        // 2: single 3-vector tile, tile_done at t0+6
        setup_tile3();
        preload(3);
        expect_run("tile3", 9);
        check("tile3_busy_k0", 64'(busy_seen[0]), 64'd1);
        check("tile3_busy_k5", 64'(busy_seen[5]), 64'd1);
        check("tile3_busy_k6", 64'(busy_seen[6]), 64'd0);
        check("tile3_busy_k8", 64'(busy_seen[8]), 64'd0);

        // 3: back-to-back tiles, B pops 4 cycles after A's last pop
        pv[0] = mkvec(16'h1000); pl[0] = 1'b0; pt[0] = 0;
        pv[1] = mkvec(16'h2000); pl[1] = 1'b1; pt[1] = 1;
        pv[2] = mkvec(16'h3000); pl[2] = 1'b1; pt[2] = 5;
        npop = 3; st_s = 0; st_l = 0; push_until = 0;
        preload(3);
        expect_run("b2b", 12);

        // 4: fill to full with array frozen; 9th vector held then accepted
        for (int i = 0; i < 9; i++) begin
            pv[i] = mkvec(16'h0100 * 16'(i) + 16'h0011);
            pl[i] = (i == 8);
            pt[i] = i;
        end
        npop = 9; st_s = 0; st_l = 0; push_until = 2;
        preload(8);
        step();
        s_valid = 1'b1;
        s_data  = pv[8];
        s_last  = 1'b1;
        #1;
        check("fill_ready_full", 64'(s_ready), 64'd0);
        check("fill_busy", 64'(busy), 64'd1);
        step();
        #1;
        check("fill_ready_held", 64'(s_ready), 64'd0);
        expect_run("fill", 15);
        check("fill_ready_pop_cycle", 64'(rdy_seen[0]), 64'd0);
        check("fill_ready_after_pop", 64'(rdy_seen[1]), 64'd1);
        s_last = 1'b0;

        // 5: 3-cycle freeze mid-tile delays tile_done by 3
        for (int i = 0; i < 4; i++) begin
            pv[i] = mkvec(16'hA000 + 16'h0010 * 16'(i));
            pl[i] = (i == 3);
            pt[i] = i;
        end
        npop = 4; st_s = 2; st_l = 3; push_until = 0;
        preload(4);
        expect_run("stall", 13);

        // 6: reset two cycles after the first pop of a 4-vector tile
        for (int i = 0; i < 4; i++) begin
            pv[i] = mkvec(16'h5000 + 16'h0010 * 16'(i));
            pl[i] = (i == 3);
        end
        preload(4);
        step(); array_en = 1'b1; s_valid = 1'b0;
        step();
        step(); reset = 1'b1;
        #1;
        check("rst_mid_tile_done", 64'(tile_done), 64'd0);
        step(); reset = 1'b0;
        #1;
        check("rst_mid_vld", 64'(ifmap_vld_o), 64'd0);
        check("rst_mid_data", ifmap_o, 64'd0);
        check("rst_mid_busy", 64'(busy), 64'd0);
        check("rst_mid_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            step();
            #1;
            check("post_rst_vld", 64'(ifmap_vld_o), 64'd0);
            check("post_rst_tile_done", 64'(tile_done), 64'd0);
        end
        setup_tile3();
        preload(3);
        expect_run("fresh", 9);
        check("fresh_busy_k6", 64'(busy_seen[6]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_sa_skew_feeder
`default_nettype wire
